// File: rtl/alu_cmd_master_if.sv
// alu_cmd_master_if: command, operand word, tx/rx byte and result signals.
// The master modport is the alu_cmd_master side; slave is the sequencer side.
interface alu_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_echo_i;
    logic [7:0]  cmd_count_i;
    logic [31:0] word_data_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  echo_data_o;
    logic        echo_valid_o;
    logic [31:0] result_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    modport master (
        input  cmd_valid_i, cmd_echo_i, cmd_count_i,
        input  word_data_i, word_valid_i,
        input  tx_ready_i, rx_data_i, rx_valid_i,
        output cmd_ready_o, word_ready_o,
        output tx_data_o, tx_valid_o, rx_ready_o,
        output echo_data_o, echo_valid_o,
        output result_o, busy_o, done_o, error_o
    );

    modport slave (
        output cmd_valid_i, cmd_echo_i, cmd_count_i,
        output word_data_i, word_valid_i,
        output tx_ready_i, rx_data_i, rx_valid_i,
        input  cmd_ready_o, word_ready_o,
        input  tx_data_o, tx_valid_o, rx_ready_o,
        input  echo_data_o, echo_valid_o,
        input  result_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: frames ADD/ECHO commands for the UART ALU responder.
// Optional response watchdog enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_WORDS      = 255,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic              clk_i,
    input logic              rst_i,
    alu_cmd_master_if.master bus
);

    if (DATA_WIDTH != 8 || MAX_WORDS < 0 || MAX_WORDS > 255 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("alu_cmd_master: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE, HDR, LOAD, PAYLOAD, RESP, FINISH
    } state_t;

    state_t      state, state_n;
    logic        echo_mode;
    logic [7:0]  n_words;
    logic [7:0]  words_sent;
    logic [1:0]  idx;
    logic [23:0] sh;
    logic [7:0]  tx_data;
    logic [23:0] acc;
    logic [31:0] result;
    logic [15:0] echo_cnt;
    logic [7:0]  echo_data;
    logic        echo_valid;

    logic [15:0] frame_len;
    logic [15:0] echo_len;
    logic [7:0]  hdr_next;
    logic        tx_valid, rx_ready;
    logic        tx_hs, rx_hs, cmd_hs, word_hs;
    logic        in_window, echo_take, echo_done, add_take;
    logic        to_hit;

    assign echo_len  = {6'd0, n_words, 2'b00};
    assign frame_len = echo_len + 16'd4;

    assign tx_valid = (state == HDR) || (state == PAYLOAD);
    assign rx_ready = !((state == FINISH) && !echo_mode);

    assign tx_hs   = tx_valid && bus.tx_ready_i;
    assign rx_hs   = rx_ready && bus.rx_valid_i;
    assign cmd_hs  = (state == IDLE) && bus.cmd_valid_i;
    assign word_hs = (state == LOAD) && bus.word_valid_i;

    assign in_window = (state == HDR) || (state == LOAD) ||
                       (state == PAYLOAD) || (state == RESP);
    assign echo_take = echo_mode && in_window && rx_hs &&
                       (echo_cnt != echo_len);
    // Look ahead one byte so done follows the last echo by one cycle.
    assign echo_done = (echo_cnt == echo_len) ||
                       (echo_take && (echo_cnt + 16'd1 == echo_len));
    assign add_take  = !echo_mode && (state == RESP) && rx_hs;

    always_comb begin
        hdr_next = 8'h00;
        unique case (idx)
            2'd1:    hdr_next = frame_len[7:0];
            2'd2:    hdr_next = frame_len[15:8];
            default: hdr_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.cmd_valid_i) state_n = HDR;
            HDR: begin
                if (tx_hs && idx == 2'd3)
                    state_n = (n_words == 8'd0) ? RESP : LOAD;
            end
            LOAD: if (bus.word_valid_i) state_n = PAYLOAD;
            PAYLOAD: begin
                if (tx_hs && idx == 2'd3)
                    state_n = (words_sent < n_words) ? LOAD : RESP;
            end
            RESP: begin
                if (to_hit)
                    state_n = IDLE;
                else if (echo_mode && echo_done)
                    state_n = FINISH;
                else if (add_take && idx == 2'd3)
                    state_n = FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            echo_mode  <= 1'b0;
            n_words    <= '0;
            words_sent <= '0;
            idx        <= '0;
            sh         <= '0;
            tx_data    <= '0;
            acc        <= '0;
            result     <= '0;
            echo_cnt   <= '0;
            echo_data  <= '0;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= 1'b0;
            if (cmd_hs) begin
                echo_mode  <= bus.cmd_echo_i;
                n_words    <= bus.cmd_count_i;
                words_sent <= '0;
                idx        <= '0;
                echo_cnt   <= '0;
                tx_data    <= bus.cmd_echo_i ? 8'hEC : 8'hAD;
            end
            if (state == HDR && tx_hs) begin
                idx     <= idx + 2'd1;
                tx_data <= hdr_next;
            end
            if (word_hs) begin
                words_sent <= words_sent + 8'd1;
                tx_data    <= bus.word_data_i[7:0];
                sh         <= bus.word_data_i[31:8];
            end
            if (state == PAYLOAD && tx_hs) begin
                idx     <= idx + 2'd1;
                tx_data <= sh[7:0];
                sh      <= {8'h00, sh[23:8]};
            end
            // Reply arrives LSB first; result only updates on the 4th byte.
            if (add_take) begin
                idx <= idx + 2'd1;
                acc <= {bus.rx_data_i, acc[23:8]};
                if (idx == 2'd3) result <= {bus.rx_data_i, acc};
            end
            if (echo_take) begin
                echo_cnt   <= echo_cnt + 16'd1;
                echo_data  <= bus.rx_data_i;
                echo_valid <= 1'b1;
            end
        end
    end

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          err;

    assign to_hit = (state == RESP) && !rx_hs &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err <= to_hit;
            if (state != RESP || rx_hs) to_cnt <= '0;
            else                        to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus.error_o = err;
`else
    assign to_hit      = 1'b0;
    assign bus.error_o = 1'b0;
`endif

    assign bus.cmd_ready_o  = (state == IDLE);
    assign bus.word_ready_o = (state == LOAD);
    assign bus.tx_data_o    = tx_data;
    assign bus.tx_valid_o   = tx_valid;
    assign bus.rx_ready_o   = rx_ready;
    assign bus.echo_data_o  = echo_data;
    assign bus.echo_valid_o = echo_valid;
    assign bus.result_o     = result;
    assign bus.busy_o       = (state != IDLE);
    assign bus.done_o       = (state == FINISH);

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: scoreboard bench acting as sequencer and ALU responder.
// Define ALU_CMD_TIMEOUT_EN to also exercise the response watchdog.
module tb_alu_cmd_master;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1_000_000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_master_if bus_if ();

    alu_cmd_master #(
        .DATA_WIDTH(8),
        .MAX_WORDS(255),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;
    int tx_count = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    bit cur_echo = 1'b0;
    bit wr_seen = 1'b0;
    bit stall_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_echo[$];
    logic [31:0] exp_res[$];
    logic [31:0] words[$];
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int left = 0;
        bus_if.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && left > 0) begin
                bus_if.tx_ready_i = 1'b0;
                left--;
            end else begin
                bus_if.tx_ready_i = 1'b1;
                left = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
        end
    end

    // Monitor: tx bytes, stall hold, echo bytes and done/result scoreboard.
    always @(negedge clk) begin
        logic [7:0]  e;
        logic [31:0] r;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus_if.tx_valid_o && prev_stall) begin
                checks++;
                if (bus_if.tx_data_o !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %02h expected %02h",
                             bus_if.tx_data_o, prev_data);
                end
            end
            if (bus_if.tx_valid_o && bus_if.tx_ready_i) begin
                checks++;
                tx_count++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: got %02h expected none",
                             bus_if.tx_data_o);
                end else begin
                    e = exp_tx.pop_front();
                    if (bus_if.tx_data_o !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h expected %02h",
                                 bus_if.tx_data_o, e);
                    end
                end
            end
            prev_stall = bus_if.tx_valid_o && !bus_if.tx_ready_i;
            prev_data  = bus_if.tx_data_o;
            if (bus_if.word_ready_o) wr_seen = 1'b1;
            if (bus_if.echo_valid_o) begin
                checks++;
                if (exp_echo.size() == 0) begin
                    errors++;
                    $display("FAIL echo_extra: got %02h expected none",
                             bus_if.echo_data_o);
                end else begin
                    e = exp_echo.pop_front();
                    if (bus_if.echo_data_o !== e) begin
                        errors++;
                        $display("FAIL echo_byte: got %02h expected %02h",
                                 bus_if.echo_data_o, e);
                    end
                end
            end
            if (bus_if.done_o) begin
                done_cnt++;
                checks++;
                if (cur_echo) begin
                    if (exp_echo.size() != 0) begin
                        errors++;
                        $display("FAIL echo_early_done: got %0d left expected 0",
                                 exp_echo.size());
                    end
                end else if (exp_res.size() == 0) begin
                    errors++;
                    $display("FAIL done_extra: got done expected none");
                end else begin
                    r = exp_res.pop_front();
                    if (bus_if.result_o !== r) begin
                        errors++;
                        $display("FAIL result: got %08h expected %08h",
                                 bus_if.result_o, r);
                    end
                end
            end
            if (bus_if.error_o) err_cnt++;
        end
    end

    task automatic start_cmd(input bit echo, input logic [7:0] n);
        logic [15:0] len;
        bit ok = 1'b0;
        len = 16'(4 + 4 * int'(n));
        cur_echo = echo;
        exp_tx.push_back(echo ? 8'hEC : 8'hAD);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(len[7:0]);
        exp_tx.push_back(len[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++)
                exp_tx.push_back(8'(words[i] >> (8 * b)));
        end
        @(posedge clk);
        #1;
        bus_if.cmd_echo_i  = echo;
        bus_if.cmd_count_i = n;
        bus_if.cmd_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_if.cmd_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got no ready expected ready");
        end
    endtask

    task automatic feed_words();
        foreach (words[i]) begin
            bit ok = 1'b0;
            bus_if.word_data_i  = words[i];
            bus_if.word_valid_i = 1'b1;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (bus_if.word_ready_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            bus_if.word_valid_i = 1'b0;
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL word_accept: got no ready expected ready");
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bit ok = 1'b0;
        bus_if.rx_data_i  = b;
        bus_if.rx_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_if.rx_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_if.rx_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_accept: got no ready expected ready");
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_tx.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (exp_tx.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL tx_drain: got %0d left expected 0", exp_tx.size());
        end
    endtask

    task automatic send_sum();
        logic [31:0] s = '0;
        foreach (words[i]) s += words[i];
        exp_res.push_back(s);
        last_res = s;
        for (int b = 0; b < 4; b++) send_rx(8'(s >> (8 * b)));
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 2000; k++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
            #1;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got %0d expected %0d", done_cnt, target);
        end
    endtask

    task automatic run_add(input logic [7:0] n);
        int d0 = done_cnt;
        start_cmd(1'b0, n);
        feed_words();
        wait_drain();
        send_sum();
        wait_done(d0 + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 10;
        if (bus_if.cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_cmd_ready: got %b expected 1", bus_if.cmd_ready_o);
        end
        if (bus_if.word_ready_o !== 1'b0) begin
            errors++; $display("FAIL rst_word_ready: got %b expected 0", bus_if.word_ready_o);
        end
        if (bus_if.tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_tx_valid: got %b expected 0", bus_if.tx_valid_o);
        end
        if (bus_if.tx_data_o !== 8'h00) begin
            errors++; $display("FAIL rst_tx_data: got %02h expected 00", bus_if.tx_data_o);
        end
        if (bus_if.rx_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_rx_ready: got %b expected 1", bus_if.rx_ready_o);
        end
        if (bus_if.echo_valid_o !== 1'b0 || bus_if.echo_data_o !== 8'h00) begin
            errors++; $display("FAIL rst_echo: got %b/%02h expected 0/00",
                               bus_if.echo_valid_o, bus_if.echo_data_o);
        end
        if (bus_if.result_o !== 32'h0) begin
            errors++; $display("FAIL rst_result: got %08h expected 0", bus_if.result_o);
        end
        if (bus_if.busy_o !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b expected 0", bus_if.busy_o);
        end
        if (bus_if.done_o !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b expected 0", bus_if.done_o);
        end
        if (bus_if.error_o !== 1'b0) begin
            errors++; $display("FAIL rst_error: got %b expected 0", bus_if.error_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_add();
        int d0 = done_cnt;
        words = '{32'h0000_0005, 32'h0000_000A};
        start_cmd(1'b0, 8'd2);
        checks++;
        if (bus_if.busy_o !== 1'b1 || bus_if.tx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL add_start: got busy %b tx_valid %b expected 1 1",
                     bus_if.busy_o, bus_if.tx_valid_o);
        end
        feed_words();
        wait_drain();
        send_sum();
        wait_done(d0 + 1);
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (done_cnt != d0 + 1) begin
            errors++; $display("FAIL add_done_cnt: got %0d expected %0d", done_cnt, d0 + 1);
        end
        if (bus_if.result_o !== 32'h0000_000F || bus_if.busy_o !== 1'b0) begin
            errors++; $display("FAIL add_hold: got %08h busy %b expected 0000000f busy 0",
                               bus_if.result_o, bus_if.busy_o);
        end
    endtask

    task automatic test_echo();
        int d0 = done_cnt;
        int t0 = tx_count;
        words = '{32'h4433_2211};
        exp_echo = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_cmd(1'b1, 8'd1);
        fork
            feed_words();
            begin
                for (int k = 0; k < 500; k++) begin
                    if (tx_count >= t0 + 5) break;
                    @(posedge clk);
                    #1;
                end
                send_rx(8'h11);
                send_rx(8'h22);
                send_rx(8'h33);
                send_rx(8'h44);
            end
        join
        wait_done(d0 + 1);
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (done_cnt != d0 + 1 || exp_tx.size() != 0) begin
            errors++; $display("FAIL echo_done: got %0d tx left %0d expected %0d 0",
                               done_cnt, exp_tx.size(), d0 + 1);
        end
        if (bus_if.result_o !== last_res) begin
            errors++; $display("FAIL echo_result_hold: got %08h expected %08h",
                               bus_if.result_o, last_res);
        end
    endtask

    task automatic test_add_zero();
        words = {};
        wr_seen = 1'b0;
        run_add(8'd0);
        checks++;
        if (wr_seen) begin
            errors++; $display("FAIL zero_word_ready: got 1 expected 0");
        end
    endtask

    task automatic test_stalls();
        words = {};
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        stall_en = 1'b1;
        run_add(8'd3);
        stall_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0 = tx_count;
        int d0;
        words = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        start_cmd(1'b0, 8'd3);
        bus_if.word_data_i  = 32'h0000_0001;
        bus_if.word_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_if.word_ready_o) break;
        end
        @(posedge clk);
        #1;
        bus_if.word_valid_i = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_count >= t0 + 6) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tx.delete();
        last_res = '0;
        @(negedge clk);
        checks += 3;
        if (bus_if.cmd_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0 ||
            bus_if.word_ready_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctrl: got rdy %b busy %b wr %b expected 1 0 0",
                               bus_if.cmd_ready_o, bus_if.busy_o, bus_if.word_ready_o);
        end
        if (bus_if.tx_valid_o !== 1'b0 || bus_if.tx_data_o !== 8'h00 ||
            bus_if.rx_ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_rst_bytes: got %b %02h %b expected 0 00 1",
                               bus_if.tx_valid_o, bus_if.tx_data_o, bus_if.rx_ready_o);
        end
        if (bus_if.result_o !== 32'h0 || bus_if.done_o !== 1'b0 ||
            bus_if.echo_valid_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out: got %08h %b %b expected 0 0 0",
                               bus_if.result_o, bus_if.done_o, bus_if.echo_valid_o);
        end
        d0 = done_cnt;
        words = '{32'h1234_0007, 32'h0000_0009};
        run_add(8'd2);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++; $display("FAIL mid_rst_after: got %0d expected %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        words = '{32'hFFFF_FFFF};
        run_add(8'd1);
        words = '{32'h8000_0000, 32'h8000_0001};
        run_add(8'd2);
        checks++;
        if (done_cnt != d0 + 2) begin
            errors++; $display("FAIL b2b_done: got %0d expected %0d", done_cnt, d0 + 2);
        end
    endtask

`ifdef ALU_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int t_last;
        int t_err = -1;
        words = {};
        start_cmd(1'b0, 8'd0);
        wait_drain();
        send_rx(8'h55);
        send_rx(8'h66);
        t_last = cyc;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (err_cnt > e0) begin
                t_err = cyc;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (err_cnt != e0 + 1 || t_err - t_last < 95 || t_err - t_last > 105) begin
            errors++; $display("FAIL timeout_error: got %0d pulses after %0d cycles expected 1 after ~100",
                               err_cnt - e0, t_err - t_last);
        end
        if (done_cnt != d0) begin
            errors++; $display("FAIL timeout_done: got %0d expected %0d", done_cnt, d0);
        end
        if (bus_if.result_o !== last_res) begin
            errors++; $display("FAIL timeout_result: got %08h expected %08h",
                               bus_if.result_o, last_res);
        end
    endtask
`endif

    initial begin
        bus_if.cmd_valid_i  = 1'b0;
        bus_if.cmd_echo_i   = 1'b0;
        bus_if.cmd_count_i  = '0;
        bus_if.word_data_i  = '0;
        bus_if.word_valid_i = 1'b0;
        bus_if.rx_data_i    = '0;
        bus_if.rx_valid_i   = 1'b0;
        test_reset();
        test_add();
        test_echo();
        test_add_zero();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_CMD_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
